// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package inst_loader_pkg;

  localparam int unsigned DEPTH_WORDS_DEF = 256;
  localparam int unsigned CNT_WIDTH_DEF   = 16;
  localparam int unsigned HDR_BYTES       = 2;
  localparam int unsigned BYTES_PER_WORD  = 4;
  localparam int unsigned BYTE_IDX_W      = $clog2(BYTES_PER_WORD);

  // Loader states; the checksum state exists only when the checksum is enabled.
  typedef enum logic [2:0] {
    ST_CNT_HI,
    ST_CNT_LO,
    ST_WORD,
    ST_WRITE,
`ifdef INST_LOADER_CHECKSUM_EN
    ST_CKSUM,
`endif
    ST_DONE,
    ST_ERROR
  } loader_state_e;

endpackage

// File: rtl/loader_word_shifter.sv
// Big-endian word assembler: shifts bytes in MSB first and flags the last byte of a word.
module loader_word_shifter
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        last_byte
);

  logic [BYTE_IDX_W-1:0] byte_idx;

  // Shift register and byte position; clear realigns to the first byte of a word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (shift_en) begin
      word     <= {word[23:0], in_data};
      byte_idx <= byte_idx + BYTE_IDX_W'(1);
    end
  end

  assign last_byte = (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory and
// holds the CPU until the image is complete.
// Optional: define INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

`ifdef INST_LOADER_CHECKSUM_EN
  localparam loader_state_e ST_FINAL = ST_CKSUM;
`else
  localparam loader_state_e ST_FINAL = ST_DONE;
`endif

  loader_state_e        state, state_next;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] word_idx;
  logic [CNT_WIDTH-1:0] n_hdr;
  logic [31:0]          word;
  logic                 last_byte;
  logic                 accept;
  logic                 shift_en;
  logic                 clear_idx;
  logic                 ready_next;
  logic [7:0]           unused_word_msb;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]           csum;
`endif

  assign accept          = in_valid && in_ready;
  assign n_hdr           = count | CNT_WIDTH'(in_data);
  assign unused_word_msb = word[31:24];

  loader_word_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_idx),
    .shift_en  (shift_en),
    .in_data   (in_data),
    .word      (word),
    .last_byte (last_byte)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_CNT_HI;
    else        state <= state_next;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    clear_idx  = 1'b0;
    ready_next = 1'b0;
    case (state)
      ST_CNT_HI: if (accept) state_next = ST_CNT_LO;
      ST_CNT_LO: begin
        if (accept) begin
          if (n_hdr > CNT_WIDTH'(DEPTH_WORDS)) begin
            state_next = ST_ERROR;
          end else if (n_hdr == '0) begin
            state_next = ST_FINAL;
          end else begin
            clear_idx  = 1'b1;
            state_next = ST_WORD;
          end
        end
      end
      ST_WORD: begin
        if (accept) begin
          shift_en = 1'b1;
          if (last_byte) state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if ((word_idx + CNT_WIDTH'(1)) == count) state_next = ST_FINAL;
        else                                     state_next = ST_WORD;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CKSUM: if (accept) state_next = (in_data == csum) ? ST_DONE : ST_ERROR;
`endif
      ST_DONE:  state_next = ST_DONE;
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_CNT_HI;
    endcase
    case (state_next)
      ST_CNT_HI, ST_CNT_LO, ST_WORD: ready_next = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CKSUM:                      ready_next = 1'b1;
`endif
      default:                       ready_next = 1'b0;
    endcase
  end

  // Header count, word index and running checksum.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count    <= '0;
      word_idx <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      if (accept && state == ST_CNT_HI) count <= CNT_WIDTH'({in_data, 8'h00});
      if (accept && state == ST_CNT_LO) count <= n_hdr;
      if (clear_idx)               word_idx <= '0;
      else if (state == ST_WRITE)  word_idx <= word_idx + CNT_WIDTH'(1);
`ifdef INST_LOADER_CHECKSUM_EN
      if (accept && state != ST_CKSUM) csum <= csum ^ in_data;
`endif
    end
  end

  // Registered outputs, loaded from the upcoming state so they align with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      in_ready <= ready_next;
      mem_we   <= (state_next == ST_WRITE);
      cpu_hold <= (state_next != ST_DONE);
      done     <= (state_next == ST_DONE);
      error    <= (state_next == ST_ERROR);
      if (state_next == ST_WRITE) begin
        mem_addr  <= 32'(word_idx) << 2;
        mem_wdata <= {word[23:0], in_data};
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader; honours INST_LOADER_CHECKSUM_EN when defined.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          b2b   = 0;
  logic        prev_we = 1'b0;
  logic [7:0]  sum;
  logic [63:0] wlog[$];
  logic [63:0] exp3 [3];

  inst_mem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Write logger and back-to-back strobe detector.
  always @(negedge clk) begin
    if (mem_we) wlog.push_back({mem_addr, mem_wdata});
    if (mem_we && prev_we) b2b++;
    prev_we = mem_we;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int waited;
    if (stall) begin
      while ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_timeout", 64'(waited < 40), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    sum      = sum ^ b;
  endtask

  task automatic finish_stream();
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(sum, 1'b0);
`else
    @(negedge clk);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    wlog.delete();
    b2b   = 0;
    sum   = 8'h00;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_three(input bit stall);
    logic [7:0] s [14];
    s = '{8'h00, 8'h03, 8'h20, 8'h09, 8'h00, 8'h01, 8'h20, 8'h0A, 8'h00, 8'h02,
          8'h20, 8'h0B, 8'h00, 8'h03};
    for (int i = 0; i < 14; i++) send_byte(s[i], stall);
  endtask

  initial begin
    exp3[0] = {32'h0, 32'h20090001};
    exp3[1] = {32'h4, 32'h200A0002};
    exp3[2] = {32'h8, 32'h200B0003};
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    sum      = 8'h00;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(in_ready), 64'd1);

    // Three-word image, no stalls, with write-latency and done-timing checks.
    send_byte(8'h00, 1'b0); send_byte(8'h03, 1'b0);
    send_byte(8'h20, 1'b0); send_byte(8'h09, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    chk("w0_we_latency", 64'(mem_we), 64'd1);
    chk("w0_addr", 64'(mem_addr), 64'h0);
    chk("w0_data", 64'(mem_wdata), 64'h20090001);
    chk("w0_ready_low", 64'(in_ready), 64'd0);
    send_byte(8'h20, 1'b0); send_byte(8'h0A, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h20, 1'b0); send_byte(8'h0B, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h03, 1'b0);
    chk("w2_we", 64'(mem_we), 64'd1);
    chk("w2_done_not_yet", 64'(done), 64'd0);
    chk("w2_hold_still", 64'(cpu_hold), 64'd1);
    finish_stream();
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_cpu_hold", 64'(cpu_hold), 64'd0);
    chk("t1_error", 64'(error), 64'd0);
    chk("t1_ready_low", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    chk("t1_nwrites", 64'(wlog.size()), 64'd3);
    for (int i = 0; i < 3 && i < wlog.size(); i++) chk("t1_write", wlog[i], exp3[i]);
    chk("t1_addr_hold", 64'(mem_addr), 64'h8);

    // Same image with random source stalls.
    do_reset();
    send_three(1'b1);
    finish_stream();
    repeat (2) @(negedge clk);
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_nwrites", 64'(wlog.size()), 64'd3);
    for (int i = 0; i < 3 && i < wlog.size(); i++) chk("t2_write", wlog[i], exp3[i]);
    chk("t2_no_b2b_we", 64'(b2b), 64'd0);

    // Oversized count 257.
    do_reset();
    send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0);
    repeat (3) @(negedge clk);
    chk("t3_error", 64'(error), 64'd1);
    chk("t3_ready_low", 64'(in_ready), 64'd0);
    chk("t3_cpu_hold", 64'(cpu_hold), 64'd1);
    chk("t3_done", 64'(done), 64'd0);
    chk("t3_nwrites", 64'(wlog.size()), 64'd0);

    // Empty image.
    do_reset();
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    finish_stream();
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_cpu_hold", 64'(cpu_hold), 64'd0);
    chk("t4_nwrites", 64'(wlog.size()), 64'd0);
`ifdef INST_LOADER_CHECKSUM_EN
    do_reset();
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h5A, 1'b0);
    chk("t4_bad_cksum_error", 64'(error), 64'd1);
    chk("t4_bad_cksum_done", 64'(done), 64'd0);
`endif

    // Reset in the middle of the second word, then a fresh one-word image.
    do_reset();
    send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
    do_reset();
    chk("t5_ready_after_reset", 64'(in_ready), 64'd1);
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0); send_byte(8'hEF, 1'b0);
    finish_stream();
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_nwrites", 64'(wlog.size()), 64'd1);
    if (wlog.size() > 0) chk("t5_write", wlog[0], {32'h0, 32'hDEADBEEF});

    // Full-depth image of 256 words.
    do_reset();
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'hC0, 1'b0);
      send_byte(8'(i), 1'b0);
      send_byte(8'h3C, 1'b0);
      send_byte(8'(255 - i), 1'b0);
    end
    finish_stream();
    repeat (2) @(negedge clk);
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_error", 64'(error), 64'd0);
    chk("t6_nwrites", 64'(wlog.size()), 64'd256);
    for (int i = 0; i < 256 && i < wlog.size(); i++)
      chk("t6_write", wlog[i], {32'(i * 4), 8'hC0, 8'(i), 8'h3C, 8'(255 - i)});
    chk("t6_last_addr", 64'(mem_addr), 64'h3FC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
